// File: rtl/a2d_scan_intf.sv
// a2d_scan_intf -- round-robin A2D scanner with its own SPI master.
//
// One strt_scan converts channels 0..NUM_CH-1 in order. Each conversion is
// one 16-bit SPI frame. The command {2'b00, ch, 11'h000} is shifted out MSB
// first, and the same frame returns that channel's result. The low RES_W
// bits of the returned frame go into a per-channel bank, optionally
// 1's-complemented. scan_cmplt pulses for one clk at the end of each sweep.
// With cont high at the end of a sweep, the next sweep starts straight away.
//
// Ports
//   clk, rst_n     system clock, async active-low reset
//   strt_scan      pulse: start a sweep at channel 0 (ignored unless idle)
//   cont           sampled at sweep end: 1 = chain another sweep
//   abort          pulse: drop the sweep (abort wins over strt_scan)
//   rd_chnl/rd_res combinational read port into the result bank
//   ch_vld         per-channel "holds a completed result" flags
//   busy           sweep in progress
//   scan_cmplt     1-clk end-of-sweep strobe
//   a2d_SS_n, SCLK, MOSI, MISO   SPI master pins (SCLK idles high)
//
// Frame timing, in units of H = SCLK_DIV/2 clks:
//   FRONT H | SHIFT 16 x (low H, high H) | BACK H | GAP H  -> 35H per frame.
//   SS_n is low for FRONT..BACK (34H).
module a2d_scan_intf #(
  parameter int NUM_CH   = 8,
  parameter int RES_W    = 12,
  parameter int SCLK_DIV = 32,
  parameter bit INVERT   = 1'b1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              strt_scan,
  input  logic              cont,
  input  logic              abort,
  input  logic [2:0]        rd_chnl,
  output logic [RES_W-1:0]  rd_res,
  output logic [NUM_CH-1:0] ch_vld,
  output logic              busy,
  output logic              scan_cmplt,
  output logic              a2d_SS_n,
  output logic              SCLK,
  output logic              MOSI,
  input  logic              MISO
);

  localparam int H  = SCLK_DIV / 2;
  localparam int CW = (H > 1) ? $clog2(H) : 1;

  typedef enum logic [2:0] {
    S_IDLE, S_FRONT, S_SHIFT, S_BACK, S_GAP, S_DONE
  } state_t;

  state_t                        state_q;
  logic [CW-1:0]                 cnt_q;
  logic [3:0]                    bit_q;
  logic [2:0]                    ch_q;
  logic [15:0]                   tx_q;
  logic [15:0]                   rx_q;
  logic [NUM_CH-1:0][RES_W-1:0]  bank_q;
  logic [NUM_CH-1:0]             vld_q;
  logic                          ss_n_q, sclk_q, mosi_q, busy_q, cmplt_q;

  logic                          phase_end;
  logic                          last_ch;
  logic [15:0]                   cmd;
  logic [RES_W-1:0]              wb_val;

  assign phase_end = (cnt_q == CW'(H - 1));
  assign last_ch   = (ch_q == 3'(NUM_CH - 1));
  assign cmd       = {2'b00, ch_q, 11'h000};
  assign wb_val    = INVERT ? ~rx_q[RES_W-1:0] : rx_q[RES_W-1:0];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      bit_q   <= '0;
      ch_q    <= '0;
      tx_q    <= '0;
      rx_q    <= '0;
      bank_q  <= '0;
      vld_q   <= '0;
      ss_n_q  <= 1'b1;
      sclk_q  <= 1'b1;
      mosi_q  <= 1'b0;
      busy_q  <= 1'b0;
      cmplt_q <= 1'b0;
    end else begin
      cmplt_q <= 1'b0;
      if (abort && state_q != S_IDLE) begin
        // Drop the in-flight frame. Completed bank entries stay intact, and
        // this branch also pre-empts a writeback due on this same clk.
        state_q <= S_IDLE;
        cnt_q   <= '0;
        ss_n_q  <= 1'b1;
        sclk_q  <= 1'b1;
        mosi_q  <= 1'b0;
        busy_q  <= 1'b0;
      end else begin
        case (state_q)
          S_IDLE: begin
            if (strt_scan && !abort) begin
              state_q <= S_FRONT;
              ch_q    <= '0;
              cnt_q   <= '0;
              ss_n_q  <= 1'b0;
              busy_q  <= 1'b1;
            end
          end
          S_FRONT: begin
            if (phase_end) begin
              // The first falling SCLK edge also presents the command MSB.
              state_q <= S_SHIFT;
              cnt_q   <= '0;
              bit_q   <= '0;
              sclk_q  <= 1'b0;
              mosi_q  <= cmd[15];
              tx_q    <= cmd << 1;
            end else begin
              cnt_q <= cnt_q + 1'b1;
            end
          end
          S_SHIFT: begin
            if (phase_end) begin
              cnt_q <= '0;
              if (!sclk_q) begin
                sclk_q <= 1'b1;
                rx_q   <= (rx_q << 1) | {15'd0, MISO};
              end else if (bit_q == 4'd15) begin
                // Last high phase done: SCLK stays high through BACK.
                state_q <= S_BACK;
              end else begin
                sclk_q <= 1'b0;
                mosi_q <= tx_q[15];
                tx_q   <= tx_q << 1;
                bit_q  <= bit_q + 4'd1;
              end
            end else begin
              cnt_q <= cnt_q + 1'b1;
            end
          end
          S_BACK: begin
            if (phase_end) begin
              state_q <= S_GAP;
              cnt_q   <= '0;
              ss_n_q  <= 1'b1;
              mosi_q  <= 1'b0;
              for (int i = 0; i < NUM_CH; i++) begin
                if (ch_q == 3'(i)) begin
                  bank_q[i] <= wb_val;
                  vld_q[i]  <= 1'b1;
                end
              end
            end else begin
              cnt_q <= cnt_q + 1'b1;
            end
          end
          S_GAP: begin
            if (phase_end) begin
              cnt_q <= '0;
              if (last_ch) begin
                state_q <= S_DONE;
                cmplt_q <= 1'b1;
                // busy during DONE reflects whether another sweep follows.
                busy_q  <= cont;
              end else begin
                state_q <= S_FRONT;
                ch_q    <= ch_q + 3'd1;
                ss_n_q  <= 1'b0;
              end
            end else begin
              cnt_q <= cnt_q + 1'b1;
            end
          end
          S_DONE: begin
            if (busy_q) begin
              state_q <= S_FRONT;
              ch_q    <= '0;
              cnt_q   <= '0;
              ss_n_q  <= 1'b0;
            end else begin
              state_q <= S_IDLE;
            end
          end
          default: state_q <= S_IDLE;
        endcase
      end
    end
  end

  // Read port: decode against the real channel count so out-of-range
  // indices return zero.
  always_comb begin
    rd_res = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (rd_chnl == 3'(i)) rd_res = bank_q[i];
    end
  end

  assign ch_vld     = vld_q;
  assign busy       = busy_q;
  assign scan_cmplt = cmplt_q;
  assign a2d_SS_n   = ss_n_q;
  assign SCLK       = sclk_q;
  assign MOSI       = mosi_q;

endmodule

// File: tb/tb_a2d_scan_intf.sv
`timescale 1ns/1ps
module tb_a2d_scan_intf;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  always #10 clk = ~clk;

  // DUT A: default parameters (8 ch, 12 bit, SCLK_DIV 32, inverted)
  logic        a_strt = 0, a_cont = 0, a_abort = 0, a_miso = 0;
  logic [2:0]  a_rd = 0;
  logic [11:0] a_res;
  logic [7:0]  a_vld;
  logic        a_busy, a_cmplt, a_ss, a_sclk, a_mosi;

  // DUT B: 3 ch, SCLK_DIV 4, raw
  logic        b_strt = 0, b_cont = 0, b_abort = 0, b_miso = 0;
  logic [2:0]  b_rd = 0;
  logic [11:0] b_res;
  logic [2:0]  b_vld;
  logic        b_busy, b_cmplt, b_ss, b_sclk, b_mosi;

  a2d_scan_intf u_a (
    .clk(clk), .rst_n(rst_n), .strt_scan(a_strt), .cont(a_cont), .abort(a_abort),
    .rd_chnl(a_rd), .rd_res(a_res), .ch_vld(a_vld), .busy(a_busy),
    .scan_cmplt(a_cmplt), .a2d_SS_n(a_ss), .SCLK(a_sclk), .MOSI(a_mosi), .MISO(a_miso)
  );

  a2d_scan_intf #(.NUM_CH(3), .RES_W(12), .SCLK_DIV(4), .INVERT(1'b0)) u_b (
    .clk(clk), .rst_n(rst_n), .strt_scan(b_strt), .cont(b_cont), .abort(b_abort),
    .rd_chnl(b_rd), .rd_res(b_res), .ch_vld(b_vld), .busy(b_busy),
    .scan_cmplt(b_cmplt), .a2d_SS_n(b_ss), .SCLK(b_sclk), .MOSI(b_mosi), .MISO(b_miso)
  );

  int errs = 0;
  int checks = 0;

  // ---------------- A2D slave model for DUT A ----------------
  // Bench-side frame counter picks the channel in expected order:
  // channel 3 answers 16'h0ABC, others 16'h0000.
  int          fidx_a = 0, bit_a = -1, low_a = 0, cm_a = 0;
  logic [15:0] rsp_a = 0, sh_a = 0;
  logic [15:0] cmds_a[$];
  int          lows_a[$];

  always @(negedge a_ss) begin
    rsp_a  = ((fidx_a % 8) == 3) ? 16'h0ABC : 16'h0000;
    fidx_a = fidx_a + 1;
    bit_a  = 15;
    sh_a   = 16'h0;
  end
  always @(negedge a_sclk) if (a_ss === 1'b0 && bit_a >= 0) begin
    a_miso = rsp_a[bit_a];
    bit_a  = bit_a - 1;
  end
  always @(posedge a_sclk) if (a_ss === 1'b0) sh_a = {sh_a[14:0], a_mosi};
  always @(posedge a_ss) begin
    cmds_a.push_back(sh_a);
    lows_a.push_back(low_a);
    low_a = 0;
  end
  always @(negedge clk) begin
    if (a_ss === 1'b0) low_a = low_a + 1;
    if (a_cmplt === 1'b1) cm_a = cm_a + 1;
  end

  // ---------------- A2D slave model for DUT B ----------------
  int          bit_b = -1, low_b = 0;
  logic [15:0] rsp_b = 16'hF123, sh_b = 0;
  logic [15:0] cmds_b[$];
  int          lows_b[$];

  always @(negedge b_ss) begin
    bit_b = 15;
    sh_b  = 16'h0;
  end
  always @(negedge b_sclk) if (b_ss === 1'b0 && bit_b >= 0) begin
    b_miso = rsp_b[bit_b];
    bit_b  = bit_b - 1;
  end
  always @(posedge b_sclk) if (b_ss === 1'b0) sh_b = {sh_b[14:0], b_mosi};
  always @(posedge b_ss) begin
    cmds_b.push_back(sh_b);
    lows_b.push_back(low_b);
    low_b = 0;
  end
  always @(negedge clk) if (b_ss === 1'b0) low_b = low_b + 1;

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  // ---------------- tests ----------------
  task automatic test_reset;
    #1 rst_n = 1'b0;
    #1;
    checks++;
    if ({a_ss, a_sclk, a_mosi, a_busy, a_cmplt} !== 5'b11000) begin
      errs++; $display("FAIL rst_pins_a got %b exp 11000", {a_ss, a_sclk, a_mosi, a_busy, a_cmplt});
    end
    checks++;
    if (a_vld !== 8'h00 || a_res !== 12'h000) begin
      errs++; $display("FAIL rst_vld_res_a got vld=%h res=%h exp 00/000", a_vld, a_res);
    end
    checks++;
    if ({b_ss, b_sclk, b_mosi, b_busy, b_cmplt, b_vld} !== 8'b11000_000) begin
      errs++; $display("FAIL rst_b got %b exp 11000000", {b_ss, b_sclk, b_mosi, b_busy, b_cmplt, b_vld});
    end
    cyc(3);
    rst_n = 1'b1;
    cyc(2);
  endtask

  task automatic test_sweep_default;
    int n;
    cmds_a.delete(); lows_a.delete(); fidx_a = 0;
    a_strt = 1'b1;
    @(negedge clk) a_strt = 1'b0;
    n = 1;
    checks++;
    if (a_busy !== 1'b1 || a_ss !== 1'b0) begin
      errs++; $display("FAIL start_a got busy=%b ss=%b exp 1/0", a_busy, a_ss);
    end
    while (a_cmplt !== 1'b1 && n < 6000) begin @(negedge clk); n++; end
    checks++;
    if (n != 4481) begin errs++; $display("FAIL latency_a got %0d exp 4481", n); end
    checks++;
    if (a_busy !== 1'b0 || a_ss !== 1'b1) begin
      errs++; $display("FAIL done_a got busy=%b ss=%b exp 0/1", a_busy, a_ss);
    end
    @(negedge clk);
    checks++;
    if (a_cmplt !== 1'b0 || a_busy !== 1'b0 || a_ss !== 1'b1) begin
      errs++; $display("FAIL after_done_a got cmplt=%b busy=%b ss=%b exp 0/0/1", a_cmplt, a_busy, a_ss);
    end
    checks++;
    if (cmds_a.size() != 8) begin errs++; $display("FAIL frames_a got %0d exp 8", cmds_a.size()); end
    for (int i = 0; i < 8 && i < cmds_a.size(); i++) begin
      checks++;
      if (cmds_a[i] !== 16'(i * 2048)) begin
        errs++; $display("FAIL cmd_a[%0d] got %h exp %h", i, cmds_a[i], 16'(i * 2048));
      end
      checks++;
      if (lows_a[i] != 544) begin errs++; $display("FAIL sslow_a[%0d] got %0d exp 544", i, lows_a[i]); end
    end
    checks++;
    if (a_vld !== 8'hFF) begin errs++; $display("FAIL vld_a got %h exp FF", a_vld); end
    for (int i = 0; i < 8; i++) begin
      a_rd = 3'(i); #1;
      checks++;
      if (a_res !== ((i == 3) ? 12'h543 : 12'hFFF)) begin
        errs++; $display("FAIL res_a[%0d] got %h exp %h", i, a_res, (i == 3) ? 12'h543 : 12'hFFF);
      end
    end
  endtask

  task automatic test_small_cfg;
    int n;
    cmds_b.delete(); lows_b.delete();
    @(negedge clk) b_strt = 1'b1;
    @(negedge clk) b_strt = 1'b0;
    n = 1;
    while (b_cmplt !== 1'b1 && n < 1000) begin @(negedge clk); n++; end
    checks++;
    if (n != 211) begin errs++; $display("FAIL latency_b got %0d exp 211", n); end
    @(negedge clk);
    checks++;
    if (cmds_b.size() != 3) begin errs++; $display("FAIL frames_b got %0d exp 3", cmds_b.size()); end
    for (int i = 0; i < 3 && i < cmds_b.size(); i++) begin
      checks++;
      if (cmds_b[i] !== 16'(i * 2048) || lows_b[i] != 68) begin
        errs++; $display("FAIL frame_b[%0d] got cmd=%h low=%0d exp %h/68", i, cmds_b[i], lows_b[i], 16'(i * 2048));
      end
    end
    checks++;
    if (b_vld !== 3'b111) begin errs++; $display("FAIL vld_b got %b exp 111", b_vld); end
    for (int i = 0; i < 8; i++) begin
      b_rd = 3'(i); #1;
      checks++;
      if (b_res !== ((i < 3) ? 12'h123 : 12'h000)) begin
        errs++; $display("FAIL res_b[%0d] got %h exp %h", i, b_res, (i < 3) ? 12'h123 : 12'h000);
      end
    end
  endtask

  task automatic test_reset_mid;
    fidx_a = 0;
    @(negedge clk) a_strt = 1'b1;
    @(negedge clk) a_strt = 1'b0;
    cyc(40);  // inside channel 0 SHIFT
    checks++;
    if (a_ss !== 1'b0) begin errs++; $display("FAIL midframe_a got ss=%b exp 0", a_ss); end
    #5 rst_n = 1'b0;
    #1;
    checks++;
    if ({a_ss, a_sclk, a_busy, a_vld} !== 11'b110_00000000) begin
      errs++; $display("FAIL rst_mid_a got %b exp 11000000000", {a_ss, a_sclk, a_busy, a_vld});
    end
    for (int i = 0; i < 8; i++) begin
      a_rd = 3'(i); #1;
      checks++;
      if (a_res !== 12'h000) begin errs++; $display("FAIL rst_mid_res[%0d] got %h exp 000", i, a_res); end
    end
    @(negedge clk) rst_n = 1'b1;
    cyc(2);
  endtask

  task automatic test_abort;
    int c0;
    c0 = cm_a; fidx_a = 0;
    @(negedge clk) a_strt = 1'b1;
    @(negedge clk) a_strt = 1'b0;
    cyc(4 * 560 + 16 + 100);  // channel 4 SHIFT
    checks++;
    if (a_ss !== 1'b0 || a_vld !== 8'h0F) begin
      errs++; $display("FAIL pre_abort_a got ss=%b vld=%h exp 0/0F", a_ss, a_vld);
    end
    a_abort = 1'b1;
    @(negedge clk) a_abort = 1'b0;
    checks++;
    if ({a_busy, a_ss, a_sclk} !== 3'b011) begin
      errs++; $display("FAIL abort_a got busy/ss/sclk=%b exp 011", {a_busy, a_ss, a_sclk});
    end
    cyc(600);
    checks++;
    if (cm_a != c0 || a_ss !== 1'b1) begin
      errs++; $display("FAIL abort_quiet_a got cmplt_pulses=%0d ss=%b exp 0/1", cm_a - c0, a_ss);
    end
    checks++;
    if (a_vld !== 8'h0F) begin errs++; $display("FAIL abort_vld_a got %h exp 0F", a_vld); end
    a_rd = 3'd4; #1;
    checks++;
    if (a_res !== 12'h000) begin errs++; $display("FAIL abort_bank4 got %h exp 000", a_res); end
    a_rd = 3'd3; #1;
    checks++;
    if (a_res !== 12'h543) begin errs++; $display("FAIL abort_bank3 got %h exp 543", a_res); end
  endtask

  task automatic test_cont;
    int n;
    fidx_a = 0; a_cont = 1'b1;
    @(negedge clk) a_strt = 1'b1;
    @(negedge clk) a_strt = 1'b0;
    n = 1;
    while (a_cmplt !== 1'b1 && n < 6000) begin @(negedge clk); n++; end
    checks++;
    if (n != 4481) begin errs++; $display("FAIL latency_cont got %0d exp 4481", n); end
    checks++;
    if (a_busy !== 1'b1 || a_ss !== 1'b1) begin
      errs++; $display("FAIL done_cont got busy=%b ss=%b exp 1/1", a_busy, a_ss);
    end
    cmds_a.delete();
    @(negedge clk);
    checks++;
    if (a_ss !== 1'b0 || a_busy !== 1'b1) begin
      errs++; $display("FAIL restart_cont got ss=%b busy=%b exp 0/1", a_ss, a_busy);
    end
    cyc(100);
    a_strt = 1'b1;  // ignored while busy
    @(negedge clk) a_strt = 1'b0;
    n = 0;
    while (cmds_a.size() < 3 && n < 3000) begin @(negedge clk); n++; end
    checks++;
    if (cmds_a.size() < 3) begin errs++; $display("FAIL cont_frames got %0d exp 3", cmds_a.size()); end
    for (int i = 0; i < 3 && i < cmds_a.size(); i++) begin
      checks++;
      if (cmds_a[i] !== 16'(i * 2048)) begin
        errs++; $display("FAIL cont_cmd[%0d] got %h exp %h", i, cmds_a[i], 16'(i * 2048));
      end
    end
    a_cont = 1'b0;
    @(negedge clk) a_abort = 1'b1;
    @(negedge clk) a_abort = 1'b0;
    checks++;
    if (a_busy !== 1'b0 || a_ss !== 1'b1) begin
      errs++; $display("FAIL cont_abort got busy=%b ss=%b exp 0/1", a_busy, a_ss);
    end
  endtask

  task automatic test_abort_strt_idle;
    @(negedge clk) begin a_strt = 1'b1; a_abort = 1'b1; end
    @(negedge clk) begin a_strt = 1'b0; a_abort = 1'b0; end
    checks++;
    if (a_busy !== 1'b0 || a_ss !== 1'b1) begin
      errs++; $display("FAIL idle_race got busy=%b ss=%b exp 0/1", a_busy, a_ss);
    end
    cyc(40);
    checks++;
    if ({a_busy, a_ss, a_sclk} !== 3'b011) begin
      errs++; $display("FAIL idle_race_hold got %b exp 011", {a_busy, a_ss, a_sclk});
    end
  endtask

  initial begin
    test_reset();
    test_sweep_default();
    test_small_cfg();
    test_reset_mid();
    test_abort();
    test_cont();
    test_abort_strt_idle();
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
